// File: rtl/poc_pkg.sv
// poc_pkg: shared constants and types for the parallel output controller.
// Holds the register address map, the status-register bit positions and the
// FSM state type. It also has one helper that assembles the 8-bit status
// register view used for reads.
package poc_pkg;

  // Processor-visible register addresses
  localparam logic [2:0] SR0_ADDR  = 3'b000;
  localparam logic [2:0] DATA_ADDR = 3'b001;
  localparam logic [2:0] SR6_ADDR  = 3'b110;
  localparam logic [2:0] SR7_ADDR  = 3'b111;

  // Status register bit positions
  localparam int SR_MODE_BIT  = 0;  // 0 = polling, 1 = interrupt
  localparam int SR_RDY_BIT   = 1;  // synchronised printer rdy
  localparam int SR_BUSY_BIT  = 2;  // FSM not in IDLE
  localparam int SR_OVR_BIT   = 6;  // sticky overrun
  localparam int SR_READY_BIT = 7;  // ready for a new byte

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETUP     = 2'd1,
    STROBE    = 2'd2,
    WAIT_DONE = 2'd3
  } poc_state_t;

  // Assemble the status register; bits 3..5 are unused and read as 0
  function automatic logic [7:0] pack_sr(input logic mode, input logic rdy_s,
                                         input logic busy, input logic ovr,
                                         input logic ready);
    logic [7:0] sr;
    sr               = 8'h00;
    sr[SR_MODE_BIT]  = mode;
    sr[SR_RDY_BIT]   = rdy_s;
    sr[SR_BUSY_BIT]  = busy;
    sr[SR_OVR_BIT]   = ovr;
    sr[SR_READY_BIT] = ready;
    return sr;
  endfunction

endpackage

// File: rtl/poc_sync2.sv
// poc_sync2: two-flop synchroniser with a configurable reset value.
// It brings the asynchronous printer rdy line into the clk domain.
module poc_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; the reset value matches an idle printer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/poc_ctrl.sv
// poc_ctrl: parallel output controller between the processor register bus
// and a printer. It holds a bit-addressable status register and an 8-bit
// buffer register. It runs the TR/RDY handshake for each byte and signals
// readiness through SR7 or the active-low irq.
// Optional build macro: POC_RDY_SYNC_EN. When it is defined, rdy passes
// through a 2-flop synchroniser. When it is undefined, rdy is used directly.
//
// Handshake: the processor issues one transfer by writing 0 to SR7 while SR7=1.
// pd is loaded at that edge and held stable. tr rises only after pd has been
// stable for at least one cycle. tr stays high until the printer pulls rdy low.
// SR7 returns to 1 once rdy is seen high again.
module poc_ctrl
  import poc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rw,
  input  logic [2:0] addr,
  input  logic       reg_in,
  input  logic [7:0] data_in,
  output logic       reg_out,
  output logic       irq,
  output logic [7:0] pd,
  output logic       tr,
  input  logic       rdy,
  output poc_state_t state
);

  logic       rdy_s;
  logic       sr0;
  logic       sr6;
  logic       sr7;
  logic [7:0] br;
  logic [7:0] sr_vec;

`ifdef POC_RDY_SYNC_EN
  poc_sync2 #(.RST_VAL(1'b1)) u_rdy_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rdy),
    .q     (rdy_s)
  );
`else
  assign rdy_s = rdy;
`endif

  // Status register view presented to reads
  always_comb begin
    sr_vec = pack_sr(sr0, rdy_s, (state != IDLE), sr6, sr7);
  end

  // Interrupt decoded straight from the mode and ready flops
  assign irq = ~(sr0 & sr7);

  // Register bus writes, read-data capture and the printer handshake FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr0     <= 1'b0;
      sr6     <= 1'b0;
      sr7     <= 1'b1;
      br      <= 8'h00;
      pd      <= 8'h00;
      tr      <= 1'b0;
      reg_out <= 1'b0;
      state   <= IDLE;
    end else begin
      if (rw && addr == SR0_ADDR) begin
        sr0 <= reg_in;
      end
      // SR7 is sampled before the edge, so an FSM completion on this same
      // edge still counts the write as an overrun
      if (rw && addr == DATA_ADDR) begin
        if (sr7) begin
          br <= data_in;
        end else begin
          sr6 <= 1'b1;
        end
      end
      if (rw && addr == SR6_ADDR && !reg_in) begin
        sr6 <= 1'b0;
      end
      // Address 001 is BR, which reads as 0. SR1 is therefore not reachable.
      if (!rw) begin
        reg_out <= (addr == DATA_ADDR) ? 1'b0 : sr_vec[addr];
      end

      case (state)
        IDLE: begin
          tr <= 1'b0;
          if (rw && addr == SR7_ADDR && !reg_in) begin
            sr7   <= 1'b0;
            pd    <= br;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (rdy_s) begin
            tr    <= 1'b1;
            state <= STROBE;
          end
        end
        STROBE: begin
          if (!rdy_s) begin
            tr    <= 1'b0;
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (rdy_s) begin
            sr7   <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          tr    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
